// File: rtl/ay_bus_pkg.sv
// Shared types and constants for the AY/YM2149 register-bus initiator.
// Request layout doubles as the FIFO word: {write, chip, reg_idx, data}.
package ay_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_SEL_GAP,
      ST_ADDR,
      ST_ADDR_GAP,
      ST_WDATA,
      ST_RDATA,
      ST_END_GAP
   } ay_state_e;

   localparam logic [6:0] AY_SEL_PREFIX = 7'b1111111;
   localparam logic       CHIP_AY1      = 1'b1;
   localparam logic       CHIP_AY2      = 1'b0;

   typedef struct packed {
      logic       write;
      logic       chip;
      logic [3:0] reg_idx;
      logic [7:0] data;
   } ay_req_t;

   localparam int REQ_W = $bits(ay_req_t);

endpackage

// File: rtl/ay_req_fifo.sv
// Synchronous request FIFO with combinational head read so the bus FSM can pop
// and act on the head in the same IDLE cycle. DEPTH must be a power of 2.
module ay_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok;
   logic             pop_ok;

   // Occupancy reaches exactly DEPTH only when the top bit is set.
   assign full_o     = count_q[AW];
   assign empty_o    = (count_q == '0);
   assign push_ok    = push_i && !full_o;
   assign pop_ok     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ay_bus_master.sv
// AY/YM2149 bus initiator: turns queued register requests into SEL/ADDR/DATA
// bus phases, inserting the TurboSound chip-select only when the target changes.
module ay_bus_master
   import ay_bus_pkg::*;
#(
   parameter int PHASE_CYCLES = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic       req_chip,
   input  logic [3:0] req_reg,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       bus_bdir,
   output logic       bus_bc1,
   output logic [7:0] bus_dout,
   input  logic [7:0] bus_din,
   input  logic       bus_oe_n
);
   localparam int            CW       = $clog2(PHASE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

   ay_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q;
   ay_req_t          work_q, work_d;
   logic             sel_known_q, sel_known_d;
   logic             cur_chip_q, cur_chip_d;
   logic             bdir_q, bdir_d;
   logic             bc1_q, bc1_d;
   logic [7:0]       dout_q, dout_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_data_q, rsp_data_d;

   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic [REQ_W-1:0] push_word;
   logic [REQ_W-1:0] head_word;
   ay_req_t          head;
   logic             phase_last;

   assign push_word  = {req_write, req_chip, req_reg, req_data};
   assign head       = ay_req_t'(head_word);
   assign phase_last = (cnt_q == CNT_LAST);

   ay_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_req_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (req_valid),
      .push_data_i (push_word),
      .pop_i       (pop),
      .pop_data_o  (head_word),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Bus outputs are computed for the state being entered, so they change only on transitions.
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      sel_known_d = sel_known_q;
      cur_chip_d  = cur_chip_q;
      bdir_d      = bdir_q;
      bc1_d       = bc1_q;
      dout_d      = dout_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      pop         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop    = 1'b1;
               work_d = head;
               bdir_d = 1'b1;
               bc1_d  = 1'b1;
               if (!sel_known_q || (head.chip != cur_chip_q)) begin
                  state_d = ST_SEL;
                  dout_d  = {AY_SEL_PREFIX, head.chip};
               end else begin
                  state_d = ST_ADDR;
                  dout_d  = {4'h0, head.reg_idx};
               end
            end
         end
         ST_SEL: begin
            if (phase_last) begin
               state_d     = ST_SEL_GAP;
               bdir_d      = 1'b0;
               bc1_d       = 1'b0;
               cur_chip_d  = work_q.chip;
               sel_known_d = 1'b1;
            end
         end
         ST_SEL_GAP: begin
            state_d = ST_ADDR;
            bdir_d  = 1'b1;
            bc1_d   = 1'b1;
            dout_d  = {4'h0, work_q.reg_idx};
         end
         ST_ADDR: begin
            if (phase_last) begin
               state_d = ST_ADDR_GAP;
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
            end
         end
         ST_ADDR_GAP: begin
            if (work_q.write) begin
               state_d = ST_WDATA;
               bdir_d  = 1'b1;
               bc1_d   = 1'b0;
               dout_d  = work_q.data;
            end else begin
               state_d = ST_RDATA;
               bdir_d  = 1'b0;
               bc1_d   = 1'b1;
            end
         end
         ST_WDATA: begin
            if (phase_last) begin
               state_d = ST_END_GAP;
               bdir_d  = 1'b0;
               bc1_d   = 1'b0;
            end
         end
         ST_RDATA: begin
            if (phase_last) begin
               state_d     = ST_END_GAP;
               bdir_d      = 1'b0;
               bc1_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = bus_oe_n ? 8'hFF : bus_din;
            end
         end
         ST_END_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            bdir_d  = 1'b0;
            bc1_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         sel_known_q <= 1'b0;
         cur_chip_q  <= CHIP_AY1;
         bdir_q      <= 1'b0;
         bc1_q       <= 1'b0;
         dout_q      <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         sel_known_q <= sel_known_d;
         cur_chip_q  <= cur_chip_d;
         bdir_q      <= bdir_d;
         bc1_q       <= bc1_d;
         dout_q      <= dout_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (!phase_last) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign req_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign bus_bdir  = bdir_q;
   assign bus_bc1   = bc1_q;
   assign bus_dout  = dout_q;

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: a TurboSound bus-device model answers the bus, while a
// request-level reference model predicts the phase sequence, responses and register contents.
module tb_ay_bus_master;
   localparam int P     = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic       req_chip = 1'b0;
   logic [3:0] req_reg = 4'h0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, rsp_valid, busy, bus_bdir, bus_bc1, bus_oe_n;
   logic [7:0] rsp_data, bus_dout, bus_din;

   always #5 clk = ~clk;

   ay_bus_master #(.PHASE_CYCLES(P), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_chip(req_chip), .req_reg(req_reg), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .bus_bdir(bus_bdir), .bus_bc1(bus_bc1), .bus_dout(bus_dout),
      .bus_din(bus_din), .bus_oe_n(bus_oe_n)
   );

   // TurboSound device: FF/FE latches select a chip, other latches set the register address.
   logic [7:0] ts_regs [2][16] = '{default: 8'h00};
   logic       ts_sel = 1'b1;
   logic [3:0] ts_addr = 4'h0;
   logic       disable_turboay = 1'b0;

   always @(posedge clk) begin
      if (bus_bdir && bus_bc1) begin
         if (bus_dout[7:1] == 7'h7F) ts_sel <= bus_dout[0];
         else ts_addr <= bus_dout[3:0];
      end else if (bus_bdir && !bus_bc1) begin
         ts_regs[ts_sel][ts_addr] <= bus_dout;
      end
   end
   assign bus_oe_n = !(!bus_bdir && bus_bc1 && !disable_turboay);
   assign bus_din  = ts_regs[ts_sel][ts_addr];

   typedef struct {
      bit       bdir;
      bit       bc1;
      bit [7:0] dout;
      bit       first;
   } phase_t;

   phase_t   exp_q[$];
   bit [7:0] rsp_q[$];
   bit [7:0] m_regs [2][16];
   bit       m_known = 1'b0;
   bit       m_cur = 1'b1;
   int       checks = 0;
   int       errors = 0;
   int       sel_seen = 0;
   int       rsp_cnt = 0;

   bit       run_act = 1'b0, run_bdir, run_bc1;
   bit [7:0] run_dout;
   int       run_len = 0, idle_cnt = 2, idle_before = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: expands one accepted request into its expected bus phases.
   task automatic model_accept();
      phase_t p;
      bit first = 1'b1;
      if (!m_known || req_chip != m_cur) begin
         p.bdir = 1; p.bc1 = 1; p.dout = {7'h7F, req_chip}; p.first = 1;
         exp_q.push_back(p);
         first = 1'b0; m_known = 1'b1; m_cur = req_chip;
      end
      p.bdir = 1; p.bc1 = 1; p.dout = {4'h0, req_reg}; p.first = first;
      exp_q.push_back(p);
      if (req_write) begin
         p.bdir = 1; p.bc1 = 0; p.dout = req_data; p.first = 0;
         m_regs[req_chip][req_reg] = req_data;
      end else begin
         p.bdir = 0; p.bc1 = 1; p.dout = 8'h00; p.first = 0;
         rsp_q.push_back(disable_turboay ? 8'hFF : m_regs[req_chip][req_reg]);
      end
      exp_q.push_back(p);
   endtask

   task automatic end_phase(output bit rsp_now);
      phase_t e;
      rsp_now = 1'b0;
      if (exp_q.size() == 0) begin
         chk("phase_unexpected", {22'h0, run_bdir, run_bc1, run_dout}, 32'h0);
      end else begin
         e = exp_q.pop_front();
         chk("phase_kind", {run_bdir, run_bc1}, {e.bdir, e.bc1});
         if (e.bdir) chk("phase_dout", run_dout, e.dout);
         chk("phase_len", run_len, P);
         if (e.first) chk("txn_gap_ge2", idle_before >= 2, 1);
         else chk("phase_gap", idle_before, 1);
         if (run_bdir && run_bc1 && run_dout[7:1] == 7'h7F) sel_seen++;
         if (!run_bdir && run_bc1) rsp_now = 1'b1;
      end
   endtask

   // Bus monitor and acceptance tracking, sampled away from the active edge.
   always @(negedge clk) begin
      bit rsp_now;
      rsp_now = 1'b0;
      if (reset) begin
         exp_q.delete();
         rsp_q.delete();
         m_known  = 1'b0;
         run_act  = 1'b0;
         run_len  = 0;
         idle_cnt = 2;
      end else begin
         if (req_valid && req_ready) model_accept();
         if (bus_bdir || bus_bc1) begin
            if (!run_act) begin
               run_act = 1'b1; run_bdir = bus_bdir; run_bc1 = bus_bc1; run_dout = bus_dout;
               run_len = 1; idle_before = idle_cnt; idle_cnt = 0;
            end else if (run_bdir == bus_bdir && run_bc1 == bus_bc1 &&
                         (!bus_bdir || run_dout == bus_dout)) begin
               run_len++;
            end else begin
               chk("phase_glitch", {22'h0, bus_bdir, bus_bc1, bus_dout},
                   {22'h0, run_bdir, run_bc1, run_dout});
               run_bdir = bus_bdir; run_bc1 = bus_bc1; run_dout = bus_dout;
            end
         end else begin
            if (run_act) begin
               end_phase(rsp_now);
               run_act = 1'b0;
            end
            idle_cnt++;
         end
         if (rsp_valid || rsp_now) begin
            if (rsp_valid) rsp_cnt++;
            chk("rsp_valid_timing", rsp_valid, rsp_now);
            if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_data, 32'h100);
            else chk("rsp_data", rsp_data, rsp_q.pop_front());
         end
      end
   end

   task automatic push(input bit w, input bit c, input bit [3:0] r, input bit [7:0] d);
      int  t = 0;
      bit  acc = 1'b0;
      req_valid = 1'b1; req_write = w; req_chip = c; req_reg = r; req_data = d;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         t++;
      end
      req_valid = 1'b0;
      if (!acc) chk("push_timeout", acc, 1);
      $display("req w=%0d chip=%0d reg=%0d data=%02h accepted=%0d", w, c, r, d, acc);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 400) begin
         n++;
         @(posedge clk); #1;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   typedef struct {
      bit       w;
      bit       c;
      bit [3:0] r;
      bit [7:0] d;
      bit       dis;
      int       cyc;
      int       sels;
      bit [7:0] rsp;
   } vec_t;

   vec_t vt[6];
   int   nb;

   initial begin
      int n, s0, r0, t;
      vt[0] = '{1'b1, 1'b1, 4'd7, 8'h38, 1'b0, 15, 1, 8'h00};
      vt[1] = '{1'b1, 1'b1, 4'd8, 8'h0F, 1'b0, 10, 0, 8'h00};
      vt[2] = '{1'b1, 1'b0, 4'd0, 8'h55, 1'b0, 15, 1, 8'h00};
      vt[3] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 10, 0, 8'h55};
      vt[4] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 10, 0, 8'hFF};
      vt[5] = '{1'b0, 1'b1, 4'd7, 8'h00, 1'b0, 15, 1, 8'h38};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_bdir", bus_bdir, 0);
      chk("rst_bc1", bus_bc1, 0);
      chk("rst_dout", bus_dout, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);

      for (int i = 0; i < 6; i++) begin
         disable_turboay = vt[i].dis;
         s0 = sel_seen; r0 = rsp_cnt;
         push(vt[i].w, vt[i].c, vt[i].r, vt[i].d);
         wait_idle(n);
         chk($sformatf("v%0d_cycles", i), n, vt[i].cyc + 1);
         chk($sformatf("v%0d_sel", i), sel_seen - s0, vt[i].sels);
         chk($sformatf("v%0d_rspcnt", i), rsp_cnt - r0, vt[i].w ? 0 : 1);
         if (!vt[i].w) chk($sformatf("v%0d_rsp_data", i), rsp_data, vt[i].rsp);
         chk($sformatf("v%0d_ts_sel", i), ts_sel, vt[i].c);
         if (vt[i].w) chk($sformatf("v%0d_ts_reg", i), ts_regs[vt[i].c][vt[i].r], vt[i].d);
      end
      chk("ay1_reg0_untouched", ts_regs[1][0], 8'h00);
      disable_turboay = 1'b0;

      // Queue full: one request in flight, then five more while the FSM is busy.
      push(1'b1, 1'b1, 4'h1, 8'hA0);
      fork
         wait_idle(nb);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) push(1'b1, 1'b1, 4'(2 + k), 8'(8'hA1 + k));
            chk("full_ready_low", req_ready, 0);
            push(1'b1, 1'b1, 4'h6, 8'hA5);
         end
      join
      chk("burst_busy_cycles", nb, 66);

      // Reset during the second WDATA cycle, with a read queued behind the write.
      push(1'b1, 1'b1, 4'h9, 8'h3C);
      push(1'b0, 1'b0, 4'h0, 8'h00);
      t = 0;
      while (!(bus_bdir && !bus_bc1) && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wdata_seen", bus_bdir && !bus_bc1, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_bdir", bus_bdir, 0);
      chk("rstmid_bc1", bus_bc1, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_ready", req_ready, 1);
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rstmid_dropped", busy, 0);
      s0 = sel_seen;
      push(1'b1, 1'b1, 4'h9, 8'h3C);
      wait_idle(n);
      chk("rstmid_resel_cycles", n, 16);
      chk("rstmid_resel", sel_seen - s0, 1);

      // Randomised traffic against the reference model.
      for (int k = 0; k < 60; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         if (k % 15 == 14) begin
            wait_idle(n);
            disable_turboay = 1'($urandom_range(0, 1));
         end
      end
      wait_idle(n);
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 16; r++)
            chk($sformatf("reg_c%0d_r%0d", c, r), ts_regs[c][r], m_regs[c][r]);
      chk("exp_phases_drained", exp_q.size(), 0);
      chk("exp_rsps_drained", rsp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Initiator side of the AY/YM2149 register bus consumed by the turbosound block.
- Takes queued register read/write requests from an internal client (tracker replay engine, test sequencer) and turns each into correctly sequenced bdir/bc1/data bus phases.
- Issues the TurboSound chip-select command (latch of 8'hFF or 8'hFE) whenever the target chip differs from the last one selected.
- Sits in the audio subsystem beside the CPU port decoder and is muxed onto the same bus when the CPU is idle.

Parameters:
- PHASE_CYCLES, 4, clk cycles each active bus phase is held; must be at least 2.
- FIFO_DEPTH, 4, request queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock (same domain as turbosound clk)
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  queue can accept; transfer occurs when req_valid && req_ready
- req_write  in  1  1 = register write, 0 = register read
- req_chip  in  1  1 = first AY, 0 = second AY (same encoding as din[0] of the select command)
- req_reg  in  4  AY register index 0..15
- req_data  in  8  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse when read data is available
- rsp_data  out  8  read result; held until the next rsp_valid
- busy  out  1  FSM not in IDLE, or queue non-empty
- bus_bdir  out  1  to turbosound bdir
- bus_bc1  out  1  to turbosound bc1
- bus_dout  out  8  to turbosound din
- bus_din  in  8  from turbosound dout
- bus_oe_n  in  1  from turbosound oe_n; low = read data valid

Behaviour:
- Reset values:
  - bus_bdir = bus_bc1 = 0, bus_dout = 8'h00.
  - rsp_valid = 0, rsp_data = 8'h00.
  - req_ready = 1, busy = 0.
  - Queue flushed; sel_known = 0; cur_chip = 1.
- Reset asserted mid-transaction: abort, drive bus idle on the next cycle, drop the queued requests.
- Queue: FIFO of {write, chip, reg, data}.
  - req_ready = !full.
  - A push while full is impossible (ready is low).
  - A pop and a push in the same cycle are both honoured.
- FSM states: IDLE, SEL, SEL_GAP, ADDR, ADDR_GAP, WDATA, RDATA, END_GAP.
- IDLE: if the queue is non-empty, pop the head into working registers. Next state:
  - SEL, if !sel_known or chip != cur_chip;
  - otherwise ADDR.
- SEL:
  - Drive bdir = 1, bc1 = 1, dout = {7'b1111111, chip} for PHASE_CYCLES cycles.
  - On exit: cur_chip = chip, sel_known = 1. Next state SEL_GAP.
- ADDR:
  - Drive bdir = 1, bc1 = 1, dout = {4'h0, reg} for PHASE_CYCLES cycles.
  - Next state ADDR_GAP.
- Gap states (SEL_GAP, ADDR_GAP, END_GAP):
  - Exactly 1 cycle of bdir = 0, bc1 = 0. bus_dout holds its previous value.
  - SEL_GAP goes to ADDR. ADDR_GAP goes to WDATA for a write, RDATA for a read. END_GAP goes to IDLE.
- WDATA:
  - Drive bdir = 1, bc1 = 0, dout = data for PHASE_CYCLES cycles.
  - Next state END_GAP.
- RDATA:
  - Drive bdir = 0, bc1 = 1 for PHASE_CYCLES cycles.
  - On the last cycle of the phase, sample: rsp_data = bus_oe_n ? 8'hFF : bus_din.
  - rsp_valid pulses on the following cycle, coinciding with the first END_GAP cycle.
  - Next state END_GAP.
- Phase counter: counts 0..PHASE_CYCLES-1, cleared on every state entry.
- Outputs are registered. Bus signals change only on state transitions.
- Latency, measured from the pop cycle (IDLE) to the return to IDLE:
  - write without select: 2*PHASE_CYCLES + 2 cycles;
  - write with select: 3*PHASE_CYCLES + 3 cycles;
  - reads: same as writes.
  - Back-to-back queued requests leave no extra idle cycle beyond END_GAP plus the IDLE pop cycle.
- Registers 14/15 are not special-cased; index bits [7:4] of the address phase are always 0.

Decomposition:
- Shared package ay_bus_pkg holds:
  - the state enum;
  - AY_SEL_PREFIX = 7'b1111111;
  - CHIP_AY1 = 1'b1 and CHIP_AY2 = 1'b0;
  - the request struct type {write, chip, reg[3:0], data[7:0]}.
- One sub-module: ay_req_fifo, a parameterised synchronous FIFO (depth FIFO_DEPTH, width 14) with full and empty flags.

Test Plan:
- Write after reset, PHASE_CYCLES = 4: write chip = 1, reg = 7, data = 8'h38.
  - Bus shows SEL 8'hFF for 4 cycles, then gap, then ADDR 8'h07 for 4 cycles, then gap, then WDATA 8'h38 for 4 cycles with bdir = 1/bc1 = 0, then gap.
  - 15 cycles total; the turbosound model's AY1 reg7 = 8'h38.
- Repeat write, no select: second write, chip = 1, reg = 8, data = 8'h0F.
  - No SEL phase; 10 cycles; AY1 reg8 = 8'h0F.
- Chip switch: write chip = 0, reg = 0, data = 8'h55.
  - SEL drives 8'hFE; the model's ay_select becomes 0; AY2 reg0 = 8'h55; AY1 reg0 unchanged.
- Read: read chip = 0, reg = 0.
  - RDATA drives bdir = 0/bc1 = 1; rsp_valid pulses once with rsp_data = 8'h55.
  - With disable_turboay = 1 in the model, oe_n stays high and rsp_data = 8'hFF.
- Queue full: push 5 requests with FIFO_DEPTH = 4 while the FSM is busy.
  - req_ready drops after the 4th accepted push; all 4 execute in order; busy falls the cycle after the final END_GAP.
- Reset mid-WDATA: assert reset during cycle 2 of WDATA.
  - Next cycle: bdir = bc1 = 0, queue empty, busy = 0.
  - The next request issues SEL even though the chip is unchanged (sel_known cleared).
